magic_dual_port_mem: RTL and testbench

//  Behavioural dual-port "magic" memory for pre-cache CPU bring-up (CP1).

---
 rtl/magic_dual_port_mem.sv | 213 +++++++++++++++++++++
 tb/tb_magic_dual_port_mem.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_dual_port_mem.sv
// Behavioural dual-port word memory for pre-cache core bring-up: read-only i-port, read/write d-port,
// fixed-latency responses. Define MAGIC_MEM_CHECK_EN to enable sticky per-port protocol error flags.

module magic_mem_port #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [31:0]           addr,
    input  logic [3:0]            wmask,
    input  logic [31:0]           wdata,
    output logic                  fire,
    output logic                  resp,
    output logic                  error,
    output logic [DEPTH_LOG2-1:0] idx,
    output logic                  wr_en,
    output logic [3:0]            wr_mask,
    output logic [31:0]           wr_data
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wmask_q;
    logic          wr_q;
    logic          req, take, acc_wr;
    logic [31:0]   acc_addr;

    assign req = req_rd | req_wr;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        fire    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: if (req) begin
                    take  = 1'b1;
                    cnt_n = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_n = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_n = RESP;
                        fire    = 1'b1;
                    end
                end
                RESP:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            addr_q  <= addr;
            wr_q    <= req_wr;
            wmask_q <= wmask;
            wdata_q <= wdata;
        end
    end

    // With LATENCY==1 the access fires on the accepting edge, so IDLE forwards the live request.
    assign acc_addr = (state == IDLE) ? addr   : addr_q;
    assign acc_wr   = (state == IDLE) ? req_wr : wr_q;
    assign wr_mask  = (state == IDLE) ? wmask  : wmask_q;
    assign wr_data  = (state == IDLE) ? wdata  : wdata_q;
    assign idx      = DEPTH_LOG2'((acc_addr - BASE_ADDR) >> 2);
    assign wr_en    = fire & acc_wr;
    assign resp     = (state == RESP);

`ifdef MAGIC_MEM_CHECK_EN
    logic        rd_q, viol, err_q;
    logic [31:0] off;

    always_ff @(posedge clk) begin
        if (take) rd_q <= req_rd;
    end

    assign off  = addr - BASE_ADDR;
    assign viol = (req && addr[1:0] != 2'b00)
               || (req_rd && req_wr)
               || (req && (off >> (DEPTH_LOG2 + 2)) != 32'd0)
               || (state == WAIT && (!req || addr != addr_q || req_rd != rd_q ||
                                     req_wr != wr_q || wmask != wmask_q || wdata != wdata_q));

    always_ff @(posedge clk) begin
        if (rst)       err_q <= 1'b0;
        else if (viol) err_q <= 1'b1;
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif
endmodule

module magic_dual_port_mem #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_read,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    output logic        i_error,
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        d_error
);
    localparam int NP    = 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [NP-1:0]                 req_rd, req_wr, fire, resp, error, wr_en;
    logic [NP-1:0][31:0]           addr, wdata, wr_data, rd_word, wr_word, rdata_q;
    logic [NP-1:0][3:0]            wmask, wr_mask;
    logic [NP-1:0][DEPTH_LOG2-1:0] idx;

    logic [31:0] mem [DEPTH] = '{default: '0};

    // Port 0 is the instruction port (never writes), port 1 the data port.
    assign req_rd = {d_read, i_read};
    assign req_wr = {d_write, 1'b0};
    assign addr   = {d_addr, i_addr};
    assign wmask  = {d_wmask, 4'h0};
    assign wdata  = {d_wdata, 32'h0};

    for (genvar p = 0; p < NP; p++) begin : g_port
        magic_mem_port #(
            .DEPTH_LOG2(DEPTH_LOG2),
            .BASE_ADDR (BASE_ADDR),
            .LATENCY   (LATENCY)
        ) u_port (
            .clk    (clk),
            .rst    (rst),
            .req_rd (req_rd[p]),
            .req_wr (req_wr[p]),
            .addr   (addr[p]),
            .wmask  (wmask[p]),
            .wdata  (wdata[p]),
            .fire   (fire[p]),
            .resp   (resp[p]),
            .error  (error[p]),
            .idx    (idx[p]),
            .wr_en  (wr_en[p]),
            .wr_mask(wr_mask[p]),
            .wr_data(wr_data[p])
        );
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rd_word[p] = mem[idx[p]];
            wr_word[p] = rd_word[p];
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[p][b]) wr_word[p][8*b +: 8] = wr_data[p][8*b +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write, so a colliding i-read sees the old word.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (rst)          rdata_q[p] <= '0;
            else if (fire[p]) rdata_q[p] <= rd_word[p];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (wr_en[p]) mem[idx[p]] <= wr_word[p];
        end
    end

    assign i_rdata = rdata_q[0];
    assign d_rdata = rdata_q[1];
    assign i_resp  = resp[0];
    assign d_resp  = resp[1];
    assign i_error = error[0];
    assign d_error = error[1];
endmodule

// File: tb/tb_magic_dual_port_mem.sv
// Randomised scoreboard bench for magic_dual_port_mem: drivers push expected words/cycles from a
// word-array model, a monitor pops and compares on every response pulse.

module tb_magic_dual_port_mem;
    localparam int          DL    = 10;
    localparam int          DEPTH = 1 << DL;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [3:0]  d_wmask = '0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_resp, i_error, d_resp, d_error;

    magic_dual_port_mem #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp), .i_error(i_error),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_error(d_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        iq[$], dq[$];
    logic [31:0] model [DEPTH];

    function automatic exp_t mk(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        return e;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = (a - BASE) >> 2;
        return int'(w % DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] raddr();
        int          w;
        logic [31:0] a;
        w = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : DEPTH - 1 - int'($urandom_range(0, 7));
        a = BASE + 32'(4 * w);
`ifndef MAGIC_MEM_CHECK_EN
        a = a + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'(4 * DEPTH);
`endif
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing/unexpected expected=per-model", name);
    endtask

    // Monitor: every response pulse must match the oldest expectation, in data and cycle.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (i_resp) begin
                if (iq.size() == 0) fail_now("i_spurious_resp");
                else begin
                    exp_t e;
                    e = iq.pop_front();
                    check("i_rdata", i_rdata, e.data);
                    check("i_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (d_resp) begin
                if (dq.size() == 0) fail_now("d_spurious_resp");
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    check("d_rdata", d_rdata, e.data);
                    check("d_resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
`ifndef MAGIC_MEM_CHECK_EN
            check("i_error_tied", 32'(i_error), 32'd0);
            check("d_error_tied", 32'(d_error), 32'd0);
`endif
        end
    end

    task automatic d_op(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] wd, input bit with_i, input logic [31:0] ia);
        int w;
        bit done;
        @(posedge clk); #1;
        w = widx(a);
        if (with_i) iq.push_back(mk(model[widx(ia)], cyc + LAT));
        dq.push_back(mk(model[w], cyc + LAT));
        if (wr) model[w] = merge(model[w], wd, m);
        d_addr = a; d_read = rd; d_write = wr; d_wmask = m; d_wdata = wd;
        if (with_i) begin
            i_addr = ia;
            i_read = 1'b1;
        end
        done = 1'b0;
        for (int t = 0; t < LAT + 8 && !done; t++) begin
            @(posedge clk); #2;
            done = d_resp;
        end
        if (!done) fail_now("d_timeout");
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b0;
    endtask

    task automatic i_op(input logic [31:0] a);
        bit done;
        @(posedge clk); #1;
        iq.push_back(mk(model[widx(a)], cyc + LAT));
        i_addr = a; i_read = 1'b1;
        done = 1'b0;
        for (int t = 0; t < LAT + 8 && !done; t++) begin
            @(posedge clk); #2;
            done = i_resp;
        end
        if (!done) fail_now("i_timeout");
        i_read = 1'b0;
    endtask

    // Held request: back-to-back responses spaced LATENCY+1 apart.
    task automatic i_hold(input logic [31:0] a);
        int n;
        @(posedge clk); #1;
        iq.push_back(mk(model[widx(a)], cyc + LAT));
        iq.push_back(mk(model[widx(a)], cyc + 2 * LAT + 1));
        i_addr = a; i_read = 1'b1;
        n = 0;
        for (int t = 0; t < 2 * LAT + 10 && n < 2; t++) begin
            @(posedge clk); #2;
            if (i_resp) n++;
        end
        if (n < 2) fail_now("i_hold_timeout");
        i_read = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_i_resp", 32'(i_resp), 32'd0);
        check("rst_d_resp", 32'(d_resp), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_i_error", 32'(i_error), 32'd0);
        check("rst_d_error", 32'(d_error), 32'd0);

        // Full write then read back
        d_op(0, 1, BASE, 4'hF, 32'hDEAD_BEEF, 0, '0);
        d_op(1, 0, BASE, 4'h0, '0, 0, '0);
        // Partial byte mask
        d_op(0, 1, BASE + 4, 4'hF, 32'h1122_3344, 0, '0);
        d_op(0, 1, BASE + 4, 4'b0101, 32'hAABB_CCDD, 0, '0);
        d_op(1, 0, BASE + 4, 4'h0, '0, 0, '0);
        // Zero mask write leaves the word alone
        d_op(0, 1, BASE + 4, 4'h0, 32'hFFFF_FFFF, 0, '0);
        d_op(1, 0, BASE + 4, 4'h0, '0, 0, '0);
        // Same-edge collision: i-port sees the pre-write word
        d_op(0, 1, BASE + 8, 4'hF, 32'h0000_0055, 1, BASE + 8);
        i_op(BASE + 8);
        // Held instruction request
        i_hold(BASE);

        // Reset in the middle of a write's WAIT
        d_op(0, 1, BASE + 12, 4'hF, 32'h1234_5678, 0, '0);
        d_op(1, 0, BASE + 12, 4'h0, '0, 0, '0);
        @(posedge clk); #1;
        d_addr = BASE + 12; d_write = 1'b1; d_wmask = 4'hF; d_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; d_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_d_resp", 32'(d_resp), 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        repeat (LAT + 2) @(posedge clk);
        d_op(1, 0, BASE + 12, 4'h0, '0, 0, '0);

        // Randomised traffic
        repeat (150) begin
            logic [31:0] a, ia;
            int          kind;
            kind = int'($urandom_range(0, 3));
            a    = raddr();
            ia   = ($urandom_range(0, 1) == 1) ? a : raddr();
            case (kind)
                0: d_op(1, 0, a, 4'($urandom_range(0, 15)), $urandom, 0, '0);
                1: d_op(0, 1, a, 4'($urandom_range(0, 15)), $urandom, 0, '0);
                2: d_op(0, 1, a, 4'($urandom_range(0, 15)), $urandom, 1, ia);
                default: i_op(ia);
            endcase
        end

`ifdef MAGIC_MEM_CHECK_EN
        check("clean_i_error", 32'(i_error), 32'd0);
        check("clean_d_error", 32'(d_error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d_op(1, 0, BASE + 2, 4'h0, '0, 0, '0);
        check("misalign_d_error", 32'(d_error), 32'd1);
        check("misalign_i_error", 32'(i_error), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_d_error", 32'(d_error), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_clears_d_error", 32'(d_error), 32'd0);
        d_op(1, 1, BASE, 4'hF, model[widx(BASE)], 0, '0);
        check("rdwr_d_error", 32'(d_error), 32'd1);
        check("rdwr_i_error", 32'(i_error), 32'd0);
`endif

        repeat (LAT + 4) @(posedge clk);
        #2;
        checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain actual=i%0d/d%0d pending expected=0", iq.size(), dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
